decision_trail_stack: RTL
=========================

DECISION_TRAIL_STACK -- requirements
Module: decision_trail_stack

Interface
REQ-001 Parameter DEPTH, default `MAX_VARS, maximum number of stacked decisions.
REQ-002 Parameter IDX_W, default `MAX_VARS_BITS, variable-index width; LVL_W = $clog2(DEPTH+1).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; the clock and reset ports are named clock and reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 push  in  1  push a new decision.
REQ-007 push_idx  in  IDX_W  decided variable index.
REQ-008 push_val  in  1  polarity assigned to push_idx.
REQ-009 pop  in  1  remove top entry.
REQ-010 flip  in  1  invert top polarity in place and mark it tried.
REQ-011 bj_start  in  1  start backjump (macro-dependent).
REQ-012 bj_level  in  LVL_W  target decision level for backjump.
REQ-013 top_idx / top_val / top_tried  out  IDX_W/1/1  top entry fields; zero when empty.
REQ-014 rm_valid / rm_idx / rm_val  out  1/IDX_W/1  entry removed last cycle (for unassignment).
REQ-015 level  out  LVL_W  current entry count (decision level).
REQ-016 empty / full  out  1/1  level==0 / level==DEPTH.
REQ-017 busy  out  1  backjump in progress.
REQ-018 overflow  out  1  sticky: push attempted while full.

Function
REQ-019 Entry = {idx, val, tried}; push SHALL write {push_idx, push_val, 0} at slot level and increment level at the next edge.
REQ-020 top_* SHALL be combinational from registered state, reading slot level-1; all zero when empty.
REQ-021 pop with !empty SHALL decrement level; next cycle rm_valid=1 with the removed idx/val; otherwise rm_valid=0.
REQ-022 flip with !empty SHALL set top val to ~val and tried=1 at the next edge; level unchanged; no rm_valid.
REQ-023 Command priority per cycle, idle state: bj_start > push > pop > flip; lower commands in the same cycle are ignored.
REQ-024 push while full SHALL leave the stack unchanged and set overflow until reset.
REQ-025 pop or flip while empty SHALL be ignored with no flag change.
REQ-026 FSM states IDLE, UNWIND; IDLE->UNWIND on bj_start with bj_level < level; bj_start with bj_level >= level is a no-op.
REQ-027 In UNWIND, busy=1, and the FSM SHALL remove exactly one top entry per cycle, each reported on rm_* one cycle later.
REQ-028 UNWIND->IDLE at the edge where level becomes bj_level (value captured at bj_start); busy low from the following cycle.
REQ-029 While busy, push/pop/flip/bj_start SHALL be ignored and SHALL NOT set overflow.
REQ-030 Unwinding K levels: busy high exactly K cycles; rm_valid high exactly K cycles, lagging busy by one.

Reset
REQ-031 Reset SHALL force level=0, empty=1, full=0, busy=0, overflow=0, rm_valid=0, FSM=IDLE; it takes effect mid-UNWIND and discards remaining removals.
REQ-032 Storage array contents need not be reset; top_* SHALL read zero while empty.

Configuration
REQ-033 Macro DECISION_TRAIL_BACKJUMP_EN: defined -> UNWIND FSM present per REQ-026..030.
REQ-034 Undefined -> bj_start and bj_level ignored, busy tied 0, only single-entry pop removes entries; all other behaviour identical.

Verification
REQ-035 Reset, push (3,1),(7,0),(5,1) -> level=3, top_idx=5, top_val=1, top_tried=0, empty=0.
REQ-036 With that stack, flip -> top_val=0, top_tried=1; then pop -> next cycle rm_valid=1, rm_idx=5, rm_val=0, level=2, top_idx=7.
REQ-037 DEPTH=4 filled, push plus pop in the same cycle -> push wins, ignored, overflow=1, level=4; pop on empty stack -> no rm_valid.
REQ-038 BACKJUMP_EN, level=5, bj_level=1 -> busy 4 cycles; rm_idx sequence top-down; level=1; push during busy ignored.
REQ-039 Reset asserted on the second UNWIND cycle -> next cycle level=0, busy=0, rm_valid=0, overflow=0.
REQ-040 Macro undefined, bj_start with bj_level=0 at level=3 -> no change, busy stays 0.

Source files
------------

// File: rtl/decision_trail_stack.sv
// Decision trail for a DPLL-style solver: LIFO of {idx, val, tried} with flip and removal reporting.
// Build option DECISION_TRAIL_BACKJUMP_EN adds a multi-cycle unwind to a target level.

`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

// state  | meaning
// IDLE   | accepting push/pop/flip/bj_start commands
// UNWIND | removing one top entry per cycle until level reaches the captured target

module decision_trail_stack #(
  parameter int DEPTH = `MAX_VARS,
  parameter int IDX_W = `MAX_VARS_BITS,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_val,
  input  logic             pop,
  input  logic             flip,
  input  logic             bj_start,
  input  logic [LVL_W-1:0] bj_level,
  output logic [IDX_W-1:0] top_idx,
  output logic             top_val,
  output logic             top_tried,
  output logic             rm_valid,
  output logic [IDX_W-1:0] rm_idx,
  output logic             rm_val,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             busy,
  output logic             overflow
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             val;
    logic             tried;
  } entry_t;

  entry_t mem [DEPTH];

  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;
  logic              rm_valid_q;
  logic [IDX_W-1:0]  rm_idx_q;
  logic              rm_val_q;

  logic              is_empty;
  logic              is_full;
  logic [ADDR_W-1:0] wr_slot;
  logic [ADDR_W-1:0] top_slot;
  entry_t            top_entry;

  logic              accept;
  logic              bj_pop;
  logic              busy_int;
  logic              do_push;
  logic              do_pop;
  logic              do_flip;
  logic              set_ovf;

  assign is_empty  = (level_q == '0);
  assign is_full   = (level_q == LVL_W'(DEPTH));
  assign wr_slot   = ADDR_W'(level_q);
  assign top_slot  = ADDR_W'(level_q - LVL_W'(1));
  assign top_entry = mem[top_slot];

`ifdef DECISION_TRAIL_BACKJUMP_EN
  typedef enum logic {IDLE, UNWIND} state_t;

  state_t           state_q, state_d;
  logic [LVL_W-1:0] target_q, target_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    bj_pop   = 1'b0;
    busy_int = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        accept = !bj_start;
        if (bj_start && (bj_level < level_q)) begin
          state_d  = UNWIND;
          target_d = bj_level;
        end
      end
      UNWIND: begin
        busy_int = 1'b1;
        bj_pop   = 1'b1;
        // Leave on the edge that lands level exactly on the target.
        if ((level_q - LVL_W'(1)) == target_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic unused_bj;

  assign unused_bj = ^{bj_start, bj_level};
  assign accept    = 1'b1;
  assign bj_pop    = 1'b0;
  assign busy_int  = 1'b0;
`endif

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_flip = 1'b0;
    set_ovf = 1'b0;
    if (accept) begin
      if (push) begin
        if (is_full) set_ovf = 1'b1;
        else         do_push = 1'b1;
      end else if (pop) begin
        do_pop = !is_empty;
      end else if (flip) begin
        do_flip = !is_empty;
      end
    end
    if (bj_pop) do_pop = 1'b1;
  end

  // Storage is never reset; reads are masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_slot] <= '{idx: push_idx, val: push_val, tried: 1'b0};
    end else if (do_flip) begin
      mem[top_slot].val   <= ~top_entry.val;
      mem[top_slot].tried <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rm_valid_q <= 1'b0;
      rm_idx_q   <= '0;
      rm_val_q   <= 1'b0;
    end else begin
      if (do_push)     level_q <= level_q + LVL_W'(1);
      else if (do_pop) level_q <= level_q - LVL_W'(1);
      if (set_ovf) ovf_q <= 1'b1;
      rm_valid_q <= do_pop;
      if (do_pop) begin
        rm_idx_q <= top_entry.idx;
        rm_val_q <= top_entry.val;
      end
    end
  end

  assign top_idx   = is_empty ? '0   : top_entry.idx;
  assign top_val   = is_empty ? 1'b0 : top_entry.val;
  assign top_tried = is_empty ? 1'b0 : top_entry.tried;
  assign rm_valid  = rm_valid_q;
  assign rm_idx    = rm_idx_q;
  assign rm_val    = rm_val_q;
  assign level     = level_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign busy      = busy_int;
  assign overflow  = ovf_q;

endmodule
